// File: rtl/traffic_pkg.sv
// traffic_pkg: command codes, controller states and default timings shared by the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        CMD_ON         = 3'd0,
        CMD_OFF        = 3'd1,
        CMD_BLINK      = 3'd2,
        CMD_SET_GREEN  = 3'd3,
        CMD_SET_ALLRED = 3'd4,
        CMD_SET_YELLOW = 3'd5,
        CMD_SET_EN     = 3'd6,
        CMD_NOP        = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        ST_OFF, ST_YBLINK, ST_ALL_RED, ST_PREP, ST_GREEN, ST_GBLINK, ST_YELLOW
    } int_state_t;

    localparam logic [15:0] GREEN_DEF_MS  = 16'd50;
    localparam logic [15:0] YELLOW_DEF_MS = 16'd30;

endpackage

// File: rtl/tl_ms_timer.sv
// tl_ms_timer: millisecond prescaler plus 16-bit elapsed-ms counter, both restarted by clr_i.
module tl_ms_timer #(
    parameter int CLK_HZ = 2000
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        clr_i,
    output logic        last_o,
    output logic [15:0] ms_cnt_o
);

    localparam int PRE = CLK_HZ / 1000;
    localparam int PW  = PRE > 1 ? $clog2(PRE) : 1;

    logic [PW-1:0] pre;

    // last_o marks the final clock of the current millisecond
    assign last_o = pre == PW'(PRE - 1);

    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            pre      <= '0;
            ms_cnt_o <= '0;
        end else if (last_o) begin
            pre      <= '0;
            ms_cnt_o <= ms_cnt_o + 16'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: round-robin conflict-free green sequencing over NUM_DIR approaches,
// with per-direction timing and skip mask programmable while the junction blinks yellow.
module traffic_intersection_ctrl import traffic_pkg::*; #(
    parameter int NUM_DIR               = 4,
    parameter int CLK_HZ                = 2000,
    parameter int BLINK_HALF_PERIOD_MS  = 4,
    parameter int BLINK_GREEN_TIME_TICK = 8,
    parameter int RED_YELLOW_MS         = 10,
    parameter int ALL_RED_DEF_MS        = 20,
    localparam int DIR_W = NUM_DIR > 1 ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic               cmd_valid_i,
    input  logic [2:0]         cmd_type_i,
    input  logic [DIR_W-1:0]   cmd_dir_i,
    input  logic [15:0]        cmd_data_i,
    output logic [NUM_DIR-1:0] red_o,
    output logic [NUM_DIR-1:0] yellow_o,
    output logic [NUM_DIR-1:0] green_o,
    output logic [DIR_W-1:0]   active_dir_o
);

    localparam logic [15:0] HALF_MS   = 16'(BLINK_HALF_PERIOD_MS);
    localparam logic [15:0] BLINK_MS  = 16'(2 * BLINK_HALF_PERIOD_MS);
    localparam logic [15:0] GBLINK_MS = 16'(2 * BLINK_GREEN_TIME_TICK * BLINK_HALF_PERIOD_MS);
    localparam logic [15:0] PREP_MS   = 16'(RED_YELLOW_MS);

    int_state_t         state;
    cmd_t               cmd;
    logic [DIR_W-1:0]   dir;
    logic [15:0]        green_t [NUM_DIR];
    logic [15:0]        yellow_t [NUM_DIR];
    logic [15:0]        all_red_t;
    logic [NUM_DIR-1:0] en;
    logic [NUM_DIR-1:0] onehot;
    logic [15:0]        ms_cnt;
    logic [15:0]        dur;
    logic               last, expire, cmd_off, cmd_blink, cmd_on, blink_on, clr;

    // first enabled direction at or after start, wrapping; start itself when none is enabled
    function automatic logic [DIR_W-1:0] first_en(input int start, input logic [NUM_DIR-1:0] mask);
        first_en = DIR_W'(start % NUM_DIR);
        for (int i = NUM_DIR - 1; i >= 0; i--)
            if (mask[(start + i) % NUM_DIR]) first_en = DIR_W'((start + i) % NUM_DIR);
    endfunction

    tl_ms_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .clr_i   (clr),
        .last_o  (last),
        .ms_cnt_o(ms_cnt)
    );

    always_comb begin
        cmd       = cmd_t'(cmd_type_i);
        cmd_off   = cmd_valid_i && cmd == CMD_OFF && state != ST_OFF;
        cmd_blink = cmd_valid_i && cmd == CMD_BLINK && state != ST_OFF && state != ST_YBLINK;
        cmd_on    = cmd_valid_i && cmd == CMD_ON && (state == ST_OFF || state == ST_YBLINK);
        // YBLINK re-arms every full blink period so its phase never depends on counter wrap
        dur = state == ST_ALL_RED ? all_red_t :
              state == ST_PREP    ? PREP_MS :
              state == ST_GREEN   ? green_t[dir] :
              state == ST_GBLINK  ? GBLINK_MS :
              state == ST_YELLOW  ? yellow_t[dir] : BLINK_MS;
        expire   = last && ms_cnt == dur - 16'd1 && state != ST_OFF;
        clr      = cmd_off || cmd_blink || cmd_on || expire;
        blink_on = ms_cnt % BLINK_MS < HALF_MS;
        onehot   = NUM_DIR'(1) << dir;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= ST_ALL_RED;
            dir       <= '0;
            all_red_t <= 16'(ALL_RED_DEF_MS);
            en        <= '1;
            for (int i = 0; i < NUM_DIR; i++) begin
                green_t[i]  <= GREEN_DEF_MS;
                yellow_t[i] <= YELLOW_DEF_MS;
            end
            red_o        <= '1;
            yellow_o     <= '0;
            green_o      <= '0;
            active_dir_o <= '0;
        end else begin
            if (cmd_off) state <= ST_OFF;
            else if (cmd_blink) state <= ST_YBLINK;
            else if (cmd_on) begin
                state <= ST_ALL_RED;
                dir   <= first_en(0, en);
            end else if (expire) begin
                case (state)
                    ST_ALL_RED: if (|en) state <= ST_PREP;
                    ST_PREP:    state <= ST_GREEN;
                    ST_GREEN:   state <= BLINK_GREEN_TIME_TICK != 0 ? ST_GBLINK : ST_YELLOW;
                    ST_GBLINK:  state <= ST_YELLOW;
                    ST_YELLOW: begin
                        state <= ST_ALL_RED;
                        dir   <= first_en(int'(dir) + 1, en);
                    end
                    default: ;
                endcase
            end
            if (cmd_valid_i && state == ST_YBLINK) begin
                if (cmd == CMD_SET_ALLRED && cmd_data_i != 16'd0) all_red_t <= cmd_data_i;
                if (int'(cmd_dir_i) < NUM_DIR) begin
                    if (cmd == CMD_SET_GREEN && cmd_data_i != 16'd0) green_t[cmd_dir_i] <= cmd_data_i;
                    if (cmd == CMD_SET_YELLOW && cmd_data_i != 16'd0) yellow_t[cmd_dir_i] <= cmd_data_i;
                    if (cmd == CMD_SET_EN) en[cmd_dir_i] <= cmd_data_i[0];
                end
            end
            red_o <= state == ST_OFF || state == ST_YBLINK ? '0 :
                     state == ST_ALL_RED || state == ST_PREP ? '1 : ~onehot;
            yellow_o <= state == ST_YBLINK ? {NUM_DIR{blink_on}} :
                        state == ST_PREP || state == ST_YELLOW ? onehot : '0;
            green_o <= state == ST_GREEN || (state == ST_GBLINK && blink_on) ? onehot : '0;
            active_dir_o <= state == ST_OFF || state == ST_YBLINK ? '0 : dir;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: vector table, directed corner sequences and randomized commands
// checked every cycle against a phase/elapsed-time reference model.
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] C_ON = 3'd0, C_OFF = 3'd1, C_BLINK = 3'd2, C_SG = 3'd3, C_SAR = 3'd4, C_SY = 3'd5, C_EN = 3'd6;
    localparam int P_OFF = 0, P_YB = 1, P_AR = 2, P_PREP = 3, P_GRN = 4, P_GB = 5, P_YEL = 6;
    localparam int HALF_CYC = 4 * 2;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic [2:0]  cmd_type_i = 3'd0;
    logic [1:0]  cmd_dir_i = 2'd0;
    logic [15:0] cmd_data_i = 16'd0;
    logic [3:0]  red_o, yellow_o, green_o;
    logic [1:0]  active_dir_o;

    int n_cmp = 0;
    int n_bad = 0;

    int ph, e, ad, ar_ms;
    int g_ms [4];
    int y_ms [4];
    logic [3:0]  en;
    logic [13:0] exp_o;

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [1:0]  d;
        logic [15:0] x;
        int          n;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [12];

    traffic_intersection_ctrl #(
        .NUM_DIR(4), .CLK_HZ(2000), .BLINK_HALF_PERIOD_MS(4), .BLINK_GREEN_TIME_TICK(8),
        .RED_YELLOW_MS(10), .ALL_RED_DEF_MS(20)
    ) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_type_i  (cmd_type_i),
        .cmd_dir_i   (cmd_dir_i),
        .cmd_data_i  (cmd_data_i),
        .red_o       (red_o),
        .yellow_o    (yellow_o),
        .green_o     (green_o),
        .active_dir_o(active_dir_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [13:0] pk(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g, input logic [1:0] a);
        return {r, y, g, a};
    endfunction

    function automatic logic [13:0] outs();
        return {red_o, yellow_o, green_o, active_dir_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // lamp pattern implied by the model's current phase
    function automatic logic [13:0] lamps();
        logic [3:0] oh, r, y, g;
        logic bl;
        int a;
        oh = 4'(1 << ad);
        bl = (e / HALF_CYC) % 2 == 0;
        r = 4'h0; y = 4'h0; g = 4'h0; a = ad;
        if (ph == P_OFF || ph == P_YB) begin
            a = 0;
            y = (ph == P_YB && bl) ? 4'hF : 4'h0;
        end else if (ph == P_AR) r = 4'hF;
        else if (ph == P_PREP) begin
            r = 4'hF;
            y = oh;
        end else begin
            r = ~oh;
            g = (ph == P_GRN || (ph == P_GB && bl)) ? oh : 4'h0;
            y = ph == P_YEL ? oh : 4'h0;
        end
        return {r, y, g, 2'(a)};
    endfunction

    function automatic int dur();
        case (ph)
            P_AR:    return ar_ms * 2;
            P_PREP:  return 10 * 2;
            P_GRN:   return g_ms[ad] * 2;
            P_GB:    return 2 * 8 * 4 * 2;
            P_YEL:   return y_ms[ad] * 2;
            default: return 0;
        endcase
    endfunction

    function automatic int first(input int s);
        for (int k = 0; k < 4; k++) if (en[(s + k) % 4]) return (s + k) % 4;
        return s % 4;
    endfunction

    task automatic go(input int p);
        ph = p;
        e = 0;
    endtask

    task automatic model_reset();
        ph = P_AR; e = 0; ad = 0; ar_ms = 20; en = 4'hF;
        for (int k = 0; k < 4; k++) begin
            g_ms[k] = 50;
            y_ms[k] = 30;
        end
        exp_o = pk(4'hF, 4'h0, 4'h0, 2'd0);
    endtask

    task automatic model_step(input logic v, input logic [2:0] t, input logic [1:0] d, input logic [15:0] x);
        exp_o = lamps();
        if (v && ph == P_YB) begin
            if (t == C_SG && x != 0) g_ms[d] = int'(x);
            if (t == C_SAR && x != 0) ar_ms = int'(x);
            if (t == C_SY && x != 0) y_ms[d] = int'(x);
            if (t == C_EN) en[d] = x[0];
        end
        e++;
        if (v && t == C_OFF && ph != P_OFF) go(P_OFF);
        else if (v && t == C_BLINK && ph != P_OFF && ph != P_YB) go(P_YB);
        else if (v && t == C_ON && (ph == P_OFF || ph == P_YB)) begin
            ad = first(0);
            go(P_AR);
        end else if (e == dur()) begin
            case (ph)
                P_AR:    go(|en ? P_PREP : P_AR);
                P_PREP:  go(P_GRN);
                P_GRN:   go(P_GB);
                P_GB:    go(P_YEL);
                default: begin
                    ad = first(ad + 1);
                    go(P_AR);
                end
            endcase
        end
    endtask

    // one clock: present a command, advance the model, then check outputs just after the edge
    task automatic cyc(input logic v, input logic [2:0] t, input logic [1:0] d, input logic [15:0] x);
        cmd_valid_i = v; cmd_type_i = t; cmd_dir_i = d; cmd_data_i = x;
        if (srst_i) model_reset();
        else model_step(v, t, d, x);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        chk("model", 32'(outs()), 32'(exp_o));
        chk("excl", 32'(red_o == 4'h0 || $countones(~red_o) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 3'd0, 2'd0, 16'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'd0,  2'd0, 16'd0,  40,  pk(4'hF, 4'h0, 4'h0, 2'd0)};
        tbl[1]  = '{1'b0, 3'd0,  2'd0, 16'd0,  1,   pk(4'hF, 4'h1, 4'h0, 2'd0)};
        tbl[2]  = '{1'b0, 3'd0,  2'd0, 16'd0,  19,  pk(4'hF, 4'h1, 4'h0, 2'd0)};
        tbl[3]  = '{1'b0, 3'd0,  2'd0, 16'd0,  1,   pk(4'hE, 4'h0, 4'h1, 2'd0)};
        tbl[4]  = '{1'b1, C_SG,  2'd0, 16'd10, 99,  pk(4'hE, 4'h0, 4'h1, 2'd0)};
        tbl[5]  = '{1'b0, 3'd0,  2'd0, 16'd0,  1,   pk(4'hE, 4'h0, 4'h1, 2'd0)};
        tbl[6]  = '{1'b0, 3'd0,  2'd0, 16'd0,  8,   pk(4'hE, 4'h0, 4'h0, 2'd0)};
        tbl[7]  = '{1'b0, 3'd0,  2'd0, 16'd0,  120, pk(4'hE, 4'h1, 4'h0, 2'd0)};
        tbl[8]  = '{1'b0, 3'd0,  2'd0, 16'd0,  59,  pk(4'hE, 4'h1, 4'h0, 2'd0)};
        tbl[9]  = '{1'b0, 3'd0,  2'd0, 16'd0,  1,   pk(4'hF, 4'h0, 4'h0, 2'd1)};
        tbl[10] = '{1'b0, 3'd0,  2'd0, 16'd0,  40,  pk(4'hF, 4'h2, 4'h0, 2'd1)};
        tbl[11] = '{1'b0, 3'd0,  2'd0, 16'd0,  20,  pk(4'hD, 4'h0, 4'h2, 2'd1)};

        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        chk("reset", 32'(outs()), 32'(pk(4'hF, 4'h0, 4'h0, 2'd0)));
        srst_i = 1'b0;

        foreach (tbl[k]) begin
            cyc(tbl[k].v, tbl[k].t, tbl[k].d, tbl[k].x);
            run(tbl[k].n - 1);
            chk($sformatf("vec%0d", k), 32'(outs()), 32'(tbl[k].exp));
        end

        cyc(1'b1, C_OFF, 2'd0, 16'd0);
        chk("off_lag", 32'(outs()), 32'(pk(4'hD, 4'h0, 4'h2, 2'd1)));
        run(1);
        chk("off_dark", 32'(outs()), 32'd0);
        cyc(1'b1, C_BLINK, 2'd0, 16'd0);
        run(1);
        chk("blink_in_off", 32'(outs()), 32'd0);
        cyc(1'b1, C_ON, 2'd0, 16'd0);
        run(1);
        chk("on_allred", 32'(outs()), 32'(pk(4'hF, 4'h0, 4'h0, 2'd0)));

        cyc(1'b1, C_BLINK, 2'd0, 16'd0);
        run(1);
        chk("yb_on", 32'(outs()), 32'(pk(4'h0, 4'hF, 4'h0, 2'd0)));
        run(7);
        chk("yb_on_end", 32'(outs()), 32'(pk(4'h0, 4'hF, 4'h0, 2'd0)));
        run(1);
        chk("yb_off", 32'(outs()), 32'd0);
        run(8);
        chk("yb_on2", 32'(outs()), 32'(pk(4'h0, 4'hF, 4'h0, 2'd0)));

        cyc(1'b1, C_SG, 2'd2, 16'd10);
        cyc(1'b1, C_EN, 2'd1, 16'd0);
        cyc(1'b1, C_SG, 2'd0, 16'd0);
        cyc(1'b1, C_ON, 2'd0, 16'd0);
        run(349);
        chk("skip_dir1", 32'(outs()), 32'(pk(4'hF, 4'h0, 4'h0, 2'd2)));
        run(60);
        chk("g2_start", 32'(outs()), 32'(pk(4'hB, 4'h0, 4'h4, 2'd2)));
        run(28);
        chk("g2_short", 32'(outs()), 32'(pk(4'hB, 4'h0, 4'h0, 2'd2)));

        cyc(1'b1, C_BLINK, 2'd0, 16'd0);
        for (int k = 0; k < 4; k++) cyc(1'b1, C_EN, 2'(k), 16'd0);
        cyc(1'b1, C_ON, 2'd0, 16'd0);
        run(1000);
        chk("held", 32'(outs()), 32'(pk(4'hF, 4'h0, 4'h0, 2'd0)));
        cyc(1'b1, C_BLINK, 2'd0, 16'd0);
        cyc(1'b1, C_EN, 2'd3, 16'd1);
        cyc(1'b1, C_ON, 2'd0, 16'd0);
        run(41);
        chk("dir3_prep", 32'(outs()), 32'(pk(4'hF, 4'h8, 4'h0, 2'd3)));

        for (int i = 0; i < 4000; i++) begin
            srst_i = i == 2000;
            if ($urandom_range(0, 99) < 4)
                cyc(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 12)));
            else
                cyc(1'b0, 3'd0, 2'd0, 16'd0);
        end
        srst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
